capture_reader: RTL and testbench

- Read-side companion to the capture-flag memory.
- Takes a snapshot of the 7-entry capture flag vector on request, then emits the index of every captured slot in ascending order over a valid/ready stream. The collection/summary display logic consumes this stream.
- Also provides a registered captured-count and an "all captured" flag, updated every cycle from the live flags.

---
 rtl/capture_reader_if.sv | 18 +
 rtl/capture_reader.sv | 127 ++++++++++++
 tb/tb_capture_reader.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_reader_if.sv
// rtl/capture_reader_if.sv - slot-index stream between the capture reader and its consumer
//
// Signals:
//   valid - index/last are meaningful this cycle (driven by the reader)
//   ready - consumer accepts the current emission
//   index - captured slot index being emitted
//   last  - this is the highest captured slot of the snapshot
interface capture_reader_if #(
    parameter int IDX_W = 3
);
    logic             valid;
    logic             ready;
    logic [IDX_W-1:0] index;
    logic             last;

    modport master (output valid, output index, output last, input ready);
    modport slave  (input valid, input index, input last, output ready);
endinterface

// File: rtl/capture_reader.sv
// rtl/capture_reader.sv - snapshot the capture flags and stream out every captured slot index
//
// Ports:
//   i_clk      - clock, all state changes on the rising edge
//   i_rst      - synchronous active-high reset
//   i_capture  - live capture flags, bit k = slot k captured
//   i_start    - request a readout, accepted only when idle
//   rd         - index stream (valid/ready/index/last), master side
//   o_done     - one-cycle pulse at the end of a readout
//   o_busy     - readout in progress
//   o_count    - registered number of captured slots 1..N_SLOT-1
//   o_complete - registered "slots 1..N_SLOT-1 all captured"
module capture_reader #(
    parameter int N_SLOT = 7,
    parameter int IDX_W  = 3,
    parameter int CNT_W  = 3
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [N_SLOT-1:0]   i_capture,
    input  logic                i_start,
    capture_reader_if.master    rd,
    output logic                o_done,
    output logic                o_busy,
    output logic [CNT_W-1:0]    o_count,
    output logic                o_complete
);
    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    localparam logic [IDX_W-1:0] PTR_MAX = IDX_W'(N_SLOT - 1);

    state_t             state;
    state_t             state_nxt;
    logic [N_SLOT-1:0]  snapshot;
    logic [IDX_W-1:0]   pointer;
    logic [IDX_W-1:0]   index_q;
    logic               last_q;
    logic               hit;
    logic [N_SLOT-1:0]  above;
    logic               no_higher;
    logic [CNT_W-1:0]   pop;

    // Bits of the snapshot at and above the pointer; the slot is the last
    // one to emit when nothing is set strictly above it.
    assign hit       = snapshot[pointer];
    assign above     = snapshot >> pointer;
    assign no_higher = ~|above[N_SLOT-1:1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_start) state_nxt = SCAN;
            SCAN: begin
                if (hit)                     state_nxt = EMIT;
                else if (pointer == PTR_MAX) state_nxt = DONE;
            end
            EMIT: begin
                if (rd.ready) state_nxt = (pointer == PTR_MAX) ? DONE : SCAN;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd.valid = (state == EMIT);
        rd.index = index_q;
        rd.last  = last_q;
        o_done   = (state == DONE);
        o_busy   = (state != IDLE);
    end

    // Snapshot, scan pointer and the emitted index/last registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            snapshot <= '0;
            pointer  <= '0;
            index_q  <= '0;
            last_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        snapshot <= i_capture;
                        pointer  <= '0;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        index_q <= pointer;
                        last_q  <= no_higher;
                    end else if (pointer != PTR_MAX) begin
                        pointer <= pointer + IDX_W'(1);
                    end
                end
                EMIT: begin
                    if (rd.ready && pointer != PTR_MAX) pointer <= pointer + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Slot 0 is reserved and never counted.
    always_comb begin
        pop = '0;
        for (int k = 1; k < N_SLOT; k++) pop = pop + CNT_W'(i_capture[k]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_count    <= '0;
            o_complete <= 1'b0;
        end else begin
            o_count    <= pop;
            o_complete <= &i_capture[N_SLOT-1:1];
        end
    end
endmodule

// File: tb/tb_capture_reader.sv
// tb/tb_capture_reader.sv - self-checking bench for capture_reader
module tb_capture_reader;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] cap = '0;
    logic       start = 1'b0;
    logic       ready = 1'b0;
    logic       done;
    logic       busy;
    logic [2:0] count;
    logic       complete;

    capture_reader_if #(.IDX_W(3)) rd_if ();
    assign rd_if.ready = ready;

    capture_reader #(.N_SLOT(7), .IDX_W(3), .CNT_W(3)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_capture  (cap),
        .i_start    (start),
        .rd         (rd_if),
        .o_done     (done),
        .o_busy     (busy),
        .o_count    (count),
        .o_complete (complete)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: a readout is a list of per-cycle tokens (one scan
    // per slot, one emit per captured slot that waits for ready, one done).
    typedef struct {
        bit         emit;
        bit         fin;
        logic [2:0] idx;
        bit         last;
    } tok_t;

    tok_t       q[$];
    logic [2:0] cnt_exp = '0;
    logic       comp_exp = 1'b0;

    function automatic void build(input logic [6:0] c);
        tok_t t;
        logic [6:0] hi;
        for (int k = 0; k < 7; k++) begin
            t = '{emit: 1'b0, fin: 1'b0, idx: 3'd0, last: 1'b0};
            q.push_back(t);
            if (c[k]) begin
                hi = c >> (k + 1);
                t = '{emit: 1'b1, fin: 1'b0, idx: 3'(k), last: (hi == 7'd0)};
                q.push_back(t);
            end
        end
        t = '{emit: 1'b0, fin: 1'b1, idx: 3'd0, last: 1'b0};
        q.push_back(t);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            cnt_exp  = '0;
            comp_exp = 1'b0;
        end else begin
            cnt_exp  = 3'($countones(cap[6:1]));
            comp_exp = &cap[6:1];
            if (q.size() == 0) begin
                if (start) build(cap);
            end else if (!(q[0].emit && !ready)) begin
                void'(q.pop_front());
            end
        end
    end

    // Per-cycle compare plus a log of accepted emissions for literal checks.
    int         acc[$];
    int         accl[$];
    int         done_cnt = 0;
    int         busy_cnt = 0;
    int         stall_cnt = 0;

    always @(negedge clk) begin
        logic ev, ed, eb;
        eb = (q.size() > 0);
        ev = eb && q[0].emit;
        ed = eb && q[0].fin;
        chk("valid", rd_if.valid, ev);
        chk("done", done, ed);
        chk("busy", busy, eb);
        chk("count", count, cnt_exp);
        chk("complete", complete, comp_exp);
        if (ev) begin
            chk("index", rd_if.index, q[0].idx);
            chk("last", rd_if.last, q[0].last);
        end
        if (rd_if.valid && ready) begin
            acc.push_back(int'(rd_if.index));
            accl.push_back(int'(rd_if.last));
        end
        if (rd_if.valid && !ready) stall_cnt++;
        if (done) done_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_log();
        acc.delete();
        accl.delete();
        done_cnt  = 0;
        busy_cnt  = 0;
        stall_cnt = 0;
    endtask

    task automatic start_read(input logic [6:0] c);
        cap   = c;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            step();
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic chk_list(input string nm, input int e0, input int e1, input int e2, input int n);
        chk({nm, "_len"}, acc.size(), n);
        if (acc.size() == n) begin
            if (n > 0) chk({nm, "_0"}, acc[0], e0);
            if (n > 1) chk({nm, "_1"}, acc[1], e1);
            if (n > 2) chk({nm, "_2"}, acc[2], e2);
        end
    endtask

    initial begin
        int n;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_index", rd_if.index, 3'd0);
        chk("rst_last", rd_if.last, 1'b0);
        chk("rst_count", count, 3'd0);

        // Empty snapshot: no emissions, one done, 8 busy cycles.
        clear_log();
        start_read(7'b0000000);
        wait_idle(30);
        step();
        chk("empty_done", done_cnt, 1);
        chk("empty_busy", busy_cnt, 8);
        chk("empty_emit", acc.size(), 0);

        // Slots 1, 3, 6 with ready high.
        ready = 1'b1;
        cap = 7'b1001010;
        step();
        chk("count136", count, 3'd3);
        clear_log();
        start_read(7'b1001010);
        wait_idle(40);
        step();
        chk_list("emit136", 1, 3, 6, 3);
        if (accl.size() == 3) begin
            chk("last_a", accl[0], 0);
            chk("last_b", accl[1], 0);
            chk("last_c", accl[2], 1);
        end
        chk("done136", done_cnt, 1);
        chk("busy136", busy_cnt, 11);

        // Same snapshot with a 4-cycle stall at every emission.
        ready = 1'b0;
        clear_log();
        start_read(7'b1001010);
        begin
            int stall = 0;
            n = 0;
            while (busy && n < 100) begin
                if (rd_if.valid) begin
                    if (stall == 4) begin
                        ready = 1'b1;
                        stall = 0;
                    end else begin
                        ready = 1'b0;
                        stall++;
                    end
                end else begin
                    ready = 1'b0;
                end
                step();
                n++;
            end
        end
        ready = 1'b0;
        chk("stall_timeout", busy, 1'b0);
        step();
        chk_list("stall", 1, 3, 6, 3);
        chk("stall_cycles", stall_cnt, 12);
        chk("stall_busy", busy_cnt, 23);

        // Snapshot isolation: flags cleared right after acceptance.
        ready = 1'b1;
        clear_log();
        start_read(7'b0100100);
        cap = 7'b0000000;
        step();
        chk("count_clear", count, 3'd0);
        wait_idle(40);
        step();
        chk_list("isolate", 2, 5, 0, 2);

        // Start re-asserted mid-readout is ignored.
        clear_log();
        start_read(7'b1001010);
        repeat (3) step();
        start = 1'b1;
        step();
        step();
        start = 1'b0;
        wait_idle(40);
        step();
        chk("restart_done", done_cnt, 1);
        chk_list("restart", 1, 3, 6, 3);

        // Reset during EMIT aborts with no done.
        ready = 1'b0;
        clear_log();
        start_read(7'b0001000);
        n = 0;
        while (!rd_if.valid && n < 20) begin
            step();
            n++;
        end
        chk("emit_seen", rd_if.valid, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_valid", rd_if.valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        repeat (12) step();
        chk("abort_done", done_cnt, 0);

        // Count / complete, slot 0 excluded.
        ready = 1'b1;
        cap = 7'b1111110;
        step();
        chk("count_full", count, 3'd6);
        chk("complete_full", complete, 1'b1);
        cap = 7'b0000001;
        step();
        chk("count_slot0", count, 3'd0);
        chk("complete_slot0", complete, 1'b0);

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) cap = 7'($urandom);
            start = ($urandom_range(0, 3) == 0);
            ready = ($urandom_range(0, 3) != 0);
            rst   = ($urandom_range(0, 99) == 0);
            step();
        end
        rst   = 1'b0;
        start = 1'b0;
        ready = 1'b1;
        repeat (30) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
